// File: rtl/full_adder.sv
// Registered ripple-carry full adder.
// Adds two WIDTH-bit unsigned operands plus a carry-in. Sum and carry-out are
// captured in registers one clock after the operands are sampled. out_valid
// marks the cycles on which a new result was loaded. The default WIDTH=1 is the
// classic single-bit a/b/c -> sum/carry leaf cell.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; takes priority over in_valid
//   a, b      WIDTH-bit unsigned addends
//   c         carry-in
//   in_valid  operands are valid this cycle
//   sum       registered sum bits (a+b+c modulo 2^WIDTH)
//   carry     registered carry-out (bit WIDTH of a+b+c)
//   out_valid sum/carry were updated on the last clock edge
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // Internal carry chain: k[0] is the carry-in, k[WIDTH] is the carry-out.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s_c;

  assign k[0] = c;

  // One full-adder cell per bit, rippling the carry from LSB to MSB.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign s_c[i]  = a[i] ^ b[i] ^ k[i];
    assign k[i+1]  = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
  end

  // Result registers. Idle cycles hold the last result and drop out_valid,
  // so don't-care operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= s_c;
      carry     <= k[WIDTH];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Both instances share clk/rst/in_valid and take independent operands. Each
// stimulus cycle pushes the expected results to a scoreboard queue per
// instance; one clock later the entries are popped and compared.
module tb_full_adder;

  localparam int unsigned W8 = 8;

  typedef struct packed {
    logic       v;
    logic [7:0] s;
    logic       k;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          a1, b1, c1;
  logic [W8-1:0] a8, b8;
  logic          c8;
  logic          sum1, carry1, ov1;
  logic [W8-1:0] sum8;
  logic          carry8, ov8;

  exp_t q1[$];
  exp_t q8[$];

  // Reference state for the hold behaviour of each instance.
  logic       m1_s, m1_k;
  logic [7:0] m8_s;
  logic       m8_k;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(in_valid),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(in_valid),
    .sum(sum8), .carry(carry8), .out_valid(ov8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one cycle of stimulus, push expectations, then compare after the edge.
  task automatic step(input logic r, input logic iv,
                      input logic sa1, input logic sb1, input logic sc1,
                      input logic [7:0] sa8, input logic [7:0] sb8, input logic sc8,
                      input string tag);
    logic [1:0] full1;
    logic [8:0] full8;
    exp_t       e;
    rst = r; in_valid = iv;
    a1 = sa1; b1 = sb1; c1 = sc1;
    a8 = sa8; b8 = sb8; c8 = sc8;
    full1 = 2'(sa1) + 2'(sb1) + 2'(sc1);
    full8 = 9'(sa8) + 9'(sb8) + 9'(sc8);
    if (r) begin
      m1_s = 1'b0; m1_k = 1'b0; m8_s = 8'h00; m8_k = 1'b0;
    end else if (iv) begin
      m1_s = full1[0]; m1_k = full1[1]; m8_s = full8[7:0]; m8_k = full8[8];
    end
    e.v = iv & ~r; e.s = {7'b0, m1_s}; e.k = m1_k;
    q1.push_back(e);
    e.s = m8_s; e.k = m8_k;
    q8.push_back(e);

    @(posedge clk);
    #1;
    if (q1.size() == 0 || q8.size() == 0) begin
      check({tag, " scoreboard"}, 64'(0), 64'(1));
    end else begin
      e = q1.pop_front();
      check({tag, " w1 sum"},       64'(sum1),   64'(e.s[0]));
      check({tag, " w1 carry"},     64'(carry1), 64'(e.k));
      check({tag, " w1 out_valid"}, 64'(ov1),    64'(e.v));
      e = q8.pop_front();
      check({tag, " w8 sum"},       64'(sum8),   64'(e.s));
      check({tag, " w8 carry"},     64'(carry8), 64'(e.k));
      check({tag, " w8 out_valid"}, 64'(ov8),    64'(e.v));
    end
  endtask

  initial begin
    logic [2:0] abc;
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    m1_s = 1'b0; m1_k = 1'b0; m8_s = 8'h00; m8_k = 1'b0;

    // Reset with valid operands present: must be ignored.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset1");

    // Exhaustive single-bit truth table; 8-bit side gets random operands.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step(1'b0, 1'b1, abc[2], abc[1], abc[0],
           8'($urandom), 8'($urandom), 1'($urandom), $sformatf("truth%0d", i));
    end

    // Load a known result, then idle with wandering operands.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, "hold_load");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom), $sformatf("hold%0d", i));

    // 8-bit carry propagation and boundaries.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, "ripple_ff_00_1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "ones_c1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "zeros_c0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35, 8'h4A, 1'b0, "nocarry_35_4a");

    // Mid-stream reset discards the operand present that cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, "midreset");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1, "after_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "after_reset_idle");

    // Random back-to-back traffic with occasional idles.
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
